// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the CPU's byte-wide memory bus.
// Instruction fetch (IF) and load/store (LS) share one 8-bit RAM port. Each
// access is split into little-endian byte cycles, and the RAM's one-cycle
// read latency is absorbed by a separate issue index and capture index.
// While rdy_in is low the block freezes and the bus goes quiet.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  // load/store port
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  // byte-wide RAM bus
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_RD = 2'd1,
    S_LS_RD = 2'd2,
    S_LS_WR = 2'd3
  } state_t;

  typedef enum logic {
    P_IF = 1'b0,
    P_LS = 1'b1
  } port_t;

  state_t      r_state;
  state_t      w_next;
  port_t       r_last_grant;

  // Latched request; held for the whole access so the requester's inputs
  // only need to be valid in the cycle the grant is taken.
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_n;        // bytes in this access: 1, 2 or 4

  // r_iss: next byte to put on the bus.
  // r_cap: next byte to take from mem_din.
  // r_pend: a read byte was issued last cycle, so mem_din is valid now.
  logic [2:0]  r_iss;
  logic [2:0]  r_cap;
  logic        r_pend;
  logic [31:0] r_buf;

  logic        r_if_done;
  logic        r_ls_done;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;

  logic        w_busy_rd;
  logic        w_flush_if;
  logic        w_can_accept;
  logic        w_if_ok;
  logic        w_ls_ok;
  logic        w_grant_if;
  logic        w_grant_ls;
  logic        w_issue;
  logic        w_capture;
  logic        w_last_cap;
  logic        w_last_wr;
  logic [2:0]  w_ls_n;
  logic [31:0] w_byte_addr;
  logic [31:0] w_rd_word;

  // ---------------------------------------------------------------------
  // Control decode shared by the FSM and the datapath
  // ---------------------------------------------------------------------
  assign w_busy_rd    = (r_state == S_IF_RD) || (r_state == S_LS_RD);

  // A flush only aborts fetches; it beats a simultaneous stall.
  assign w_flush_if   = flush_in && (r_state == S_IF_RD);

  // The done cycle is already IDLE, but a requester still holding its level
  // there must not be granted a second time.
  assign w_can_accept = rdy_in && (r_state == S_IDLE) && !r_if_done && !r_ls_done;

  assign w_if_ok      = if_req && !flush_in;
  assign w_ls_ok      = ls_req;

  // Round-robin: with both asking, the port that did not win last time wins.
  assign w_grant_if   = w_can_accept && w_if_ok && (!w_ls_ok || (r_last_grant == P_LS));
  assign w_grant_ls   = w_can_accept && w_ls_ok && (!w_if_ok || (r_last_grant == P_IF));

  assign w_issue      = rdy_in && !w_flush_if && (r_state != S_IDLE) && (r_iss < r_n);
  assign w_capture    = rdy_in && !w_flush_if && w_busy_rd && r_pend;
  assign w_last_cap   = w_capture && (r_cap == (r_n - 3'd1));
  assign w_last_wr    = w_issue && (r_state == S_LS_WR) && (r_iss == (r_n - 3'd1));

  // Byte k lives at addr+k; the 32-bit add wraps naturally.
  assign w_byte_addr  = r_addr + {29'd0, r_iss};

  // Decode the load size; the reserved code 11 behaves as a word.
  always_comb begin
    unique case (ls_size)
      2'b00:   w_ls_n = 3'd1;
      2'b01:   w_ls_n = 3'd2;
      default: w_ls_n = 3'd4;
    endcase
  end

  // Assemble the final word so the last byte can go straight to the output.
  always_comb begin
    w_rd_word = r_buf;
    w_rd_word[{r_cap[1:0], 3'b000} +: 8] = mem_din;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // Advance the sequencer state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops sample pre-edge values.
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // Choose the next state from grants, completion and flush.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch forms.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_ls)      w_next = ls_wr ? S_LS_WR : S_LS_RD;
        else if (w_grant_if) w_next = S_IF_RD;
      end
      S_IF_RD: if (w_flush_if || w_last_cap) w_next = S_IDLE;
      S_LS_RD: if (w_last_cap)               w_next = S_IDLE;
      S_LS_WR: if (w_last_wr)                w_next = S_IDLE;
      default:                               w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: bus outputs
  // ---------------------------------------------------------------------
  // Drive the RAM bus combinationally; it reads zero whenever nothing issues.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = (r_state == S_LS_WR) && rdy_in;
    if (w_issue) begin
      mem_a = w_byte_addr;
      if (r_state == S_LS_WR) mem_dout = r_wdata[{r_iss[1:0], 3'b000} +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: request latch, byte counters, capture and done pulses
  // ---------------------------------------------------------------------
  // Track issue/capture progress and publish results on the done cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_grant <= P_IF;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_n          <= 3'd0;
      r_iss        <= 3'd0;
      r_cap        <= 3'd0;
      r_pend       <= 1'b0;
      r_buf        <= 32'd0;
      r_if_done    <= 1'b0;
      r_ls_done    <= 1'b0;
      r_if_data    <= 32'd0;
      r_ls_rdata   <= 32'd0;
    end else begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;

      if (w_grant_if || w_grant_ls) begin
        r_last_grant <= w_grant_if ? P_IF : P_LS;
        r_addr       <= w_grant_if ? if_addr : ls_addr;
        r_n          <= w_grant_if ? 3'd4 : w_ls_n;
        r_wdata      <= ls_wdata;
        r_iss        <= 3'd0;
        r_cap        <= 3'd0;
        r_pend       <= 1'b0;
        r_buf        <= 32'd0;   // upper bytes of short loads read as zero
      end else if (w_flush_if) begin
        r_pend <= 1'b0;
      end else if (!rdy_in) begin
        // The byte in flight is lost while the bus is away; rewind so it is
        // issued again after resume. Writes have nothing in flight.
        if (w_busy_rd) r_iss <= r_cap;
        r_pend <= 1'b0;
      end else begin
        if (w_issue) r_iss <= r_iss + 3'd1;
        r_pend <= w_issue && w_busy_rd;

        if (w_capture) begin
          r_buf[{r_cap[1:0], 3'b000} +: 8] <= mem_din;
          r_cap                            <= r_cap + 3'd1;
        end

        if (w_last_cap) begin
          if (r_state == S_IF_RD) begin
            r_if_data <= w_rd_word;
            r_if_done <= 1'b1;
          end else begin
            r_ls_rdata <= w_rd_word;
            r_ls_done  <= 1'b1;
          end
        end

        if (w_last_wr) r_ls_done <= 1'b1;
      end
    end
  end

  assign if_done  = r_if_done;
  assign ls_done  = r_ls_done;
  assign if_data  = r_if_data;
  assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed, table-driven bench for mem_ctrl with a byte RAM
// model that has one cycle of read latency. Inputs change on the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_data  (if_data),
    .ls_req   (ls_req),
    .ls_wr    (ls_wr),
    .ls_size  (ls_size),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_done  (ls_done),
    .ls_rdata (ls_rdata),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Byte RAM, 64 KiB aliased over the address space; read data appears
  // the cycle after its address.
  logic [7:0] ram [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05;
    ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22;
    ram[16'h2002] = 8'h33; ram[16'h2003] = 8'h44;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB;
    ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;
    mem_din = 8'h00;
    forever begin
      @(posedge clk_in);
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] = mem_dout;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          rst;
    bit          rdy;
    bit          fl;
    bit          ifr;
    logic [31:0] ifa;
    bit          lsr;
    bit          lsw;
    logic [1:0]  lsz;
    logic [31:0] lsa;
    logic [31:0] lswd;
    logic [31:0] e_a;
    bit          e_wr;
    logic [7:0]  e_dout;
    bit          e_ifd;
    bit          e_lsd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  // Request parameters copied into every row added while they are set.
  logic [31:0] p_ifa  = 32'd0;
  logic [31:0] p_lsa  = 32'd0;
  logic [31:0] p_lswd = 32'd0;
  bit          p_lsw  = 1'b0;
  logic [1:0]  p_lsz  = 2'b00;

  function automatic void row(input string n, input bit rdy, input bit fl,
                              input bit ifr, input bit lsr,
                              input logic [31:0] ea, input bit ewr, input logic [7:0] ed,
                              input bit eifd, input bit elsd, input logic [31:0] edata);
    vec_t v;
    v.name = n;   v.rst = 1'b0; v.rdy = rdy; v.fl = fl;
    v.ifr  = ifr; v.ifa = p_ifa;
    v.lsr  = lsr; v.lsw = p_lsw; v.lsz = p_lsz; v.lsa = p_lsa; v.lswd = p_lswd;
    v.e_a  = ea;  v.e_wr = ewr; v.e_dout = ed;
    v.e_ifd = eifd; v.e_lsd = elsd; v.e_data = edata;
    vecs.push_back(v);
  endfunction

  function automatic void rst_row(input string n);
    row(n, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0);
    vecs[vecs.size() - 1].rst = 1'b1;
  endfunction

  task automatic drive(input bit rdy, input bit fl, input bit ifr, input bit lsr);
    @(negedge clk_in);
    rdy_in = rdy; flush_in = fl; if_req = ifr; ls_req = lsr;
    #1;
  endtask

  initial begin
    vec_t v;
    bit   seen_done;
    bit   bus_busy;
    int   lat;

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'd0; ls_wdata = 32'd0;

    // A: 4-byte fetch at 0x1000, bytes 13 05 00 00.
    p_ifa = 32'h0000_1000;
    rst_row("A rst");
    row("A c0", 1,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("A c1", 1,0,1,0, 32'h1000, 0,8'h00, 0,0, 32'h0);
    row("A c2", 1,0,1,0, 32'h1001, 0,8'h00, 0,0, 32'h0);
    row("A c3", 1,0,1,0, 32'h1002, 0,8'h00, 0,0, 32'h0);
    row("A c4", 1,0,1,0, 32'h1003, 0,8'h00, 0,0, 32'h0);
    row("A c5", 1,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("A c6", 1,0,1,0, 32'h0,    0,8'h00, 1,0, 32'h0000_0513);
    row("A c7", 1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // B: 2-byte store at 0xFFF crossing into 0x1000.
    p_lsw = 1'b1; p_lsz = 2'b01; p_lsa = 32'h0000_0FFF; p_lswd = 32'hA1B2_C3D4;
    row("B c0", 1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("B c1", 1,0,0,1, 32'hFFF,  1,8'hD4, 0,0, 32'h0);
    row("B c2", 1,0,0,1, 32'h1000, 1,8'hC3, 0,0, 32'h0);
    row("B c3", 1,0,0,1, 32'h0,    0,8'h00, 0,1, 32'h0);
    row("B c4", 1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // C: 2-byte load of what B wrote.
    p_lsw = 1'b0;
    row("C c0", 1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("C c1", 1,0,0,1, 32'hFFF,  0,8'h00, 0,0, 32'h0);
    row("C c2", 1,0,0,1, 32'h1000, 0,8'h00, 0,0, 32'h0);
    row("C c3", 1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("C c4", 1,0,0,1, 32'h0,    0,8'h00, 0,1, 32'h0000_C3D4);
    row("C c5", 1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // D: fetch at 0x2000 with rdy_in low in cycles 3-4.
    p_ifa = 32'h0000_2000;
    row("D c0", 1,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("D c1", 1,0,1,0, 32'h2000, 0,8'h00, 0,0, 32'h0);
    row("D c2", 1,0,1,0, 32'h2001, 0,8'h00, 0,0, 32'h0);
    row("D c3", 0,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("D c4", 0,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("D c5", 1,0,1,0, 32'h2001, 0,8'h00, 0,0, 32'h0);
    row("D c6", 1,0,1,0, 32'h2002, 0,8'h00, 0,0, 32'h0);
    row("D c7", 1,0,1,0, 32'h2003, 0,8'h00, 0,0, 32'h0);
    row("D c8", 1,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("D c9", 1,0,1,0, 32'h0,    0,8'h00, 1,0, 32'h4433_2211);
    row("D c10",1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // E: if_req ignored under flush in IDLE; then a fetch flushed mid-way
    // while a 1-byte load waits.
    p_ifa = 32'h0000_3000; p_lsz = 2'b00; p_lsa = 32'h0000_2003;
    row("E c0", 1,1,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("E c1", 1,0,1,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("E c2", 1,0,1,1, 32'h3000, 0,8'h00, 0,0, 32'h0);
    row("E c3", 1,0,1,1, 32'h3001, 0,8'h00, 0,0, 32'h0);
    row("E c4", 1,1,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("E c5", 1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("E c6", 1,0,0,1, 32'h2003, 0,8'h00, 0,0, 32'h0);
    row("E c7", 1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("E c8", 1,0,0,1, 32'h0,    0,8'h00, 0,1, 32'h0000_0044);
    row("E c9", 1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // F: both requesting from reset: LS, IF, LS.
    p_ifa = 32'h0000_1000; p_lsa = 32'h0000_2000;
    rst_row("F rst");
    row("F c0", 1,0,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c1", 1,0,1,1, 32'h2000, 0,8'h00, 0,0, 32'h0);
    row("F c2", 1,0,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c3", 1,0,1,1, 32'h0,    0,8'h00, 0,1, 32'h0000_0011);
    row("F c4", 1,0,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c5", 1,0,1,1, 32'h1000, 0,8'h00, 0,0, 32'h0);
    row("F c6", 1,0,1,1, 32'h1001, 0,8'h00, 0,0, 32'h0);
    row("F c7", 1,0,1,1, 32'h1002, 0,8'h00, 0,0, 32'h0);
    row("F c8", 1,0,1,1, 32'h1003, 0,8'h00, 0,0, 32'h0);
    row("F c9", 1,0,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c10",1,0,1,1, 32'h0,    0,8'h00, 1,0, 32'h0000_05C3);
    row("F c11",1,0,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c12",1,0,1,1, 32'h2000, 0,8'h00, 0,0, 32'h0);
    row("F c13",1,0,1,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c14",1,0,1,1, 32'h0,    0,8'h00, 0,1, 32'h0000_0011);
    row("F c15",1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("F c16",1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // G: reset in the middle of a 4-byte store, then a 1-byte load.
    p_lsw = 1'b1; p_lsz = 2'b10; p_lsa = 32'h0000_4000; p_lswd = 32'h5566_7788;
    row("G c0", 1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("G c1", 1,0,0,1, 32'h4000, 1,8'h88, 0,0, 32'h0);
    row("G c2", 1,0,0,1, 32'h4001, 1,8'h77, 0,0, 32'h0);
    rst_row("G rst");
    row("G c4", 1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("G c5", 1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);
    p_lsw = 1'b0; p_lsz = 2'b00; p_lsa = 32'h0000_4001;
    row("G ld0",1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("G ld1",1,0,0,1, 32'h4001, 0,8'h00, 0,0, 32'h0);
    row("G ld2",1,0,0,1, 32'h0,    0,8'h00, 0,0, 32'h0);
    row("G ld3",1,0,0,1, 32'h0,    0,8'h00, 0,1, 32'h0000_0077);
    row("G ld4",1,0,0,0, 32'h0,    0,8'h00, 0,0, 32'h0);

    // H: size 11 load wrapping past 0xFFFFFFFF.
    p_lsz = 2'b11; p_lsa = 32'hFFFF_FFFE;
    row("H c0", 1,0,0,1, 32'h0,         0,8'h00, 0,0, 32'h0);
    row("H c1", 1,0,0,1, 32'hFFFF_FFFE, 0,8'h00, 0,0, 32'h0);
    row("H c2", 1,0,0,1, 32'hFFFF_FFFF, 0,8'h00, 0,0, 32'h0);
    row("H c3", 1,0,0,1, 32'h0,         0,8'h00, 0,0, 32'h0);
    row("H c4", 1,0,0,1, 32'h1,         0,8'h00, 0,0, 32'h0);
    row("H c5", 1,0,0,1, 32'h0,         0,8'h00, 0,0, 32'h0);
    row("H c6", 1,0,0,1, 32'h0,         0,8'h00, 0,1, 32'hDDCC_BBAA);
    row("H c7", 1,0,0,0, 32'h0,         0,8'h00, 0,0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk_in);
      rst_in = v.rst; rdy_in = v.rdy; flush_in = v.fl;
      if_req = v.ifr; if_addr = v.ifa;
      ls_req = v.lsr; ls_wr = v.lsw; ls_size = v.lsz; ls_addr = v.lsa; ls_wdata = v.lswd;
      #1;
      check({v.name, " mem_a"},    mem_a,             v.e_a);
      check({v.name, " mem_wr"},   {31'd0, mem_wr},   {31'd0, v.e_wr});
      check({v.name, " mem_dout"}, {24'd0, mem_dout}, {24'd0, v.e_dout});
      check({v.name, " if_done"},  {31'd0, if_done},  {31'd0, v.e_ifd});
      check({v.name, " ls_done"},  {31'd0, ls_done},  {31'd0, v.e_lsd});
      if (v.e_ifd)            check({v.name, " if_data"},  if_data,  v.e_data);
      if (v.e_lsd && !v.lsw)  check({v.name, " ls_rdata"}, ls_rdata, v.e_data);
      if (v.rst) begin
        check({v.name, " if_data"},  if_data,  32'd0);
        check({v.name, " ls_rdata"}, ls_rdata, 32'd0);
      end
    end

    // S1: flush together with a stall in IF_RD; the flush must win.
    rst_in = 1'b0; ls_req = 1'b0; if_addr = 32'h0000_1000;
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0); check("S1 c1 mem_a", mem_a, 32'h0000_1000);
    drive(1, 0, 1, 0); check("S1 c2 mem_a", mem_a, 32'h0000_1001);
    drive(0, 1, 1, 0); check("S1 flush+stall mem_a", mem_a, 32'h0);
    seen_done = 1'b0;
    bus_busy  = 1'b0;
    repeat (8) begin
      drive(1, 0, 0, 0);
      seen_done |= if_done;
      bus_busy  |= (mem_a != 32'd0) || mem_wr;
    end
    check("S1 no if_done after flush", {31'd0, seen_done}, 32'd0);
    check("S1 bus quiet after flush",  {31'd0, bus_busy},  32'd0);

    // S2: bounded wait for a plain fetch; latency and data.
    if_addr = 32'h0000_2000;
    drive(1, 0, 1, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(1, 0, 1, 0);
      if (if_done) begin
        lat = k;
        break;
      end
    end
    check("S2 if_done latency", lat, 32'd6);
    check("S2 if_data",         if_data, 32'h4433_2211);
    drive(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
